char_terminal_ctrl: RTL
=======================

// Module: char_terminal_ctrl
// PURPOSE
//  Sequences writes into the character buffer from the PS/2 keyboard stream: owns the text cursor.
//  Turns ASCII bytes into cell writes with wrap, newline, backspace and clear-screen.
//  Clear-screen is a multi-cycle sweep.
//  Arrow-key scancodes move the cursor.
//  Sits between the PS/2 decoder and character_buffer; drives its char_* and cursor_* ports.
// PARAMETERS
//  CHAR_HORZ_CNT  80                      columns
//  CHAR_VERT_CNT  25                      rows
//  CHAR_HORZ_W    $clog2(CHAR_HORZ_CNT)   column index width
//  CHAR_VERT_W    $clog2(CHAR_VERT_CNT)   row index width
// PORTS
//  clk            in   1            system clock
//  rst            in   1            reset; one clock, synchronous, active-high
//  ascii_vld      in   1            ASCII byte offered
//  ascii          in   8            ASCII byte
//  ascii_rdy      out  1            byte accepted when ascii_vld & ascii_rdy
//  scancode_vld   in   1            scancode pulse (no backpressure)
//  scancode       in   8            scancode
//  char_write_en  out  1            one-cycle write strobe to buffer
//  char_hpos      out  CHAR_HORZ_W  write column
//  char_vpos      out  CHAR_VERT_W  write row
//  char_symbol    out  8            write data
//  cursor_hpos    out  CHAR_HORZ_W  current cursor column
//  cursor_vpos    out  CHAR_VERT_W  current cursor row
//  busy           out  1            clear sweep in progress
// BEHAVIOUR
//  - All outputs registered.
//  - Reset values: cursor (0,0); char_write_en 0; char_hpos/char_vpos 0; char_symbol 0x00; busy 0; ascii_rdy 1.
//  - FSM: IDLE, CLEAR.
//    ascii_rdy = (state==IDLE).
//    In IDLE, an accepted byte is decoded in its accept cycle.
//    Any resulting write appears with char_write_en=1 on the next cycle (latency 1).
//    The updated cursor also appears on that next cycle.
//  - Printable 0x20..0x7E:
//    write symbol at the old cursor, then advance col.
//    At col==CNT-1: col=0, row+1.
//    At row==CNT-1 the row wraps to 0 (no scroll).
//  - 0x0D (Enter): col=0, row+1 with the same wrap; no write.
//  - 0x08 (Backspace):
//    col>0: col-1, write 0x20 at the new position.
//    col==0 and row>0: col=CNT-1, row-1, write 0x20.
//    At (0,0): no-op, no write.
//  - 0x0C (Form feed): enter CLEAR, busy=1.
//    Write 0x20 to every cell row-major, one cell per cycle.
//    Sweep takes exactly HORZ*VERT write cycles.
//    After the last write: cursor=(0,0), back to IDLE, busy=0.
//  - Other codes 0x00..0x1F and 0x7F..0xFF: accepted, ignored, cursor unchanged.
//  - Scancodes, IDLE only:
//    0x6B left, 0x74 right, 0x75 up, 0x72 down; each moves the cursor one cell.
//    Clamps at edges (no wrap); no write.
//    Other scancodes are ignored.
//  - Collisions:
//    ascii accept and scancode_vld in the same cycle: ASCII handled, scancode dropped.
//    Scancodes during CLEAR are dropped.
//  - rst mid-CLEAR aborts the sweep.
//    Next cycle: IDLE, cursor (0,0), char_write_en 0.
// CONFIGURATION
//  CHAR_TERM_CLEAR_ON_RESET_EN
//   defined: FSM leaves reset in CLEAR, busy=1, ascii_rdy=0; the sweep runs as for 0x0C.
//   undefined: FSM leaves reset in IDLE; buffer contents untouched.
// STRUCTURE
//  Package char_term_pkg:
//   state enum {IDLE, CLEAR}.
//   ASCII constants: BS 0x08, FF 0x0C, CR 0x0D, SPACE 0x20.
//   Scancode constants: LEFT 0x6B, RIGHT 0x74, UP 0x75, DOWN 0x72.
//  Sub-module char_term_sweep: row-major (col,row) counter.
//   Ports: start, step, done; reused for the clear sweep.
//  Cursor-advance logic stays inline in char_terminal_ctrl.
// TESTING
//  1. 'A' (0x41) at (0,0) -> next cycle write_en=1, pos (0,0), symbol 0x41; cursor (1,0).
//  2. Printable at (79,24) -> write at (79,24); cursor (0,0).
//  3. 0x08 at (0,3) -> write 0x20 at (79,2); cursor (79,2).
//     0x08 at (0,0) -> no write; cursor (0,0).
//  4. 0x0C -> ascii_rdy=0 for 2000 cycles; 2000 writes of 0x20 covering each cell once; then cursor (0,0), busy=0.
//  5. scancode 0x6B at (0,5) -> cursor (0,5).
//     0x72 with ascii 'x' in the same cycle -> only 'x' written, no down move.
//  6. rst at sweep cell 1000 -> no writes after reset, cursor (0,0), busy=0.
//     Repeat with CHAR_TERM_CLEAR_ON_RESET_EN: busy=1 and a full 2000-cell sweep after reset.

Source files
------------

// File: rtl/char_term_pkg.sv
// Shared types and constants for the character terminal controller.
package char_term_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // ASCII control and fill bytes
    localparam logic [7:0] AsciiBs    = 8'h08;
    localparam logic [7:0] AsciiFf    = 8'h0C;
    localparam logic [7:0] AsciiCr    = 8'h0D;
    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiTilde = 8'h7E;

    // PS/2 set-2 arrow-key scancodes
    localparam logic [7:0] ScanLeft  = 8'h6B;
    localparam logic [7:0] ScanRight = 8'h74;
    localparam logic [7:0] ScanUp    = 8'h75;
    localparam logic [7:0] ScanDown  = 8'h72;

endpackage

// File: rtl/char_term_sweep.sv
// Row-major (col,row) cell counter used to walk the whole screen during a clear.
module char_term_sweep #(
    parameter int unsigned HORZ_CNT = 80,
    parameter int unsigned VERT_CNT = 25,
    parameter int unsigned HORZ_W   = $clog2(HORZ_CNT),
    parameter int unsigned VERT_W   = $clog2(VERT_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    output logic [HORZ_W-1:0] col,
    output logic [VERT_W-1:0] row,
    output logic              done
);

    localparam logic [HORZ_W-1:0] LastCol = HORZ_W'(HORZ_CNT - 1);
    localparam logic [VERT_W-1:0] LastRow = VERT_W'(VERT_CNT - 1);
    localparam logic [HORZ_W-1:0] OneCol  = HORZ_W'(1);
    localparam logic [VERT_W-1:0] OneRow  = VERT_W'(1);

    // Counter register: start (or reset) rewinds to the first cell
    always_ff @(posedge clk) begin
        if (rst || start) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col == LastCol) begin
                col <= '0;
                row <= (row == LastRow) ? '0 : row + OneRow;
            end else begin
                col <= col + OneCol;
            end
        end
    end

    // Current cell is the final one of the sweep
    always_comb begin
        done = (col == LastCol) && (row == LastRow);
    end

endmodule

// File: rtl/char_terminal_ctrl.sv
// Character terminal controller: owns the text cursor and turns ASCII bytes and
// arrow scancodes into character-buffer writes and cursor moves.
// Optional build macro CHAR_TERM_CLEAR_ON_RESET_EN: leave reset already sweeping
// the screen clear instead of idling.
module char_terminal_ctrl
    import char_term_pkg::*;
#(
    parameter int unsigned CHAR_HORZ_CNT = 80,
    parameter int unsigned CHAR_VERT_CNT = 25,
    parameter int unsigned CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
    parameter int unsigned CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ascii_vld,
    input  logic [7:0]             ascii,
    output logic                   ascii_rdy,
    input  logic                   scancode_vld,
    input  logic [7:0]             scancode,
    output logic                   char_write_en,
    output logic [CHAR_HORZ_W-1:0] char_hpos,
    output logic [CHAR_VERT_W-1:0] char_vpos,
    output logic [7:0]             char_symbol,
    output logic [CHAR_HORZ_W-1:0] cursor_hpos,
    output logic [CHAR_VERT_W-1:0] cursor_vpos,
    output logic                   busy
);

    localparam logic [CHAR_HORZ_W-1:0] LastCol = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
    localparam logic [CHAR_VERT_W-1:0] LastRow = CHAR_VERT_W'(CHAR_VERT_CNT - 1);
    localparam logic [CHAR_HORZ_W-1:0] OneCol  = CHAR_HORZ_W'(1);
    localparam logic [CHAR_VERT_W-1:0] OneRow  = CHAR_VERT_W'(1);

    state_e                 state_q, state_d;
    logic [CHAR_HORZ_W-1:0] cur_col_q, cur_col_d, wr_col_q, wr_col_d;
    logic [CHAR_VERT_W-1:0] cur_row_q, cur_row_d, wr_row_q, wr_row_d;
    logic [7:0]             sym_q, sym_d;
    logic                   we_q, we_d, busy_q, busy_d, rdy_q;
    logic [CHAR_HORZ_W-1:0] adv_col, sweep_col;
    logic [CHAR_VERT_W-1:0] adv_row, nl_row, sweep_row;
    logic                   sweep_start, sweep_step, sweep_done;

    char_term_sweep #(
        .HORZ_CNT (CHAR_HORZ_CNT),
        .VERT_CNT (CHAR_VERT_CNT),
        .HORZ_W   (CHAR_HORZ_W),
        .VERT_W   (CHAR_VERT_W)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .start (sweep_start),
        .step  (sweep_step),
        .col   (sweep_col),
        .row   (sweep_row),
        .done  (sweep_done)
    );

    // Cursor successors: next cell (wrapping, no scroll) and start of next line
    always_comb begin
        nl_row = (cur_row_q == LastRow) ? '0 : cur_row_q + OneRow;
        if (cur_col_q == LastCol) begin
            adv_col = '0;
            adv_row = nl_row;
        end else begin
            adv_col = cur_col_q + OneCol;
            adv_row = cur_row_q;
        end
    end

    // Next-state decode of bytes, scancodes and the clear sweep
    always_comb begin
        state_d     = state_q;
        cur_col_d   = cur_col_q;
        cur_row_d   = cur_row_q;
        we_d        = 1'b0;
        wr_col_d    = wr_col_q;
        wr_row_d    = wr_row_q;
        sym_d       = sym_q;
        busy_d      = busy_q;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (ascii_vld) begin
                    // ASCII wins over a coincident scancode
                    if (ascii >= AsciiSpace && ascii <= AsciiTilde) begin
                        we_d      = 1'b1;
                        wr_col_d  = cur_col_q;
                        wr_row_d  = cur_row_q;
                        sym_d     = ascii;
                        cur_col_d = adv_col;
                        cur_row_d = adv_row;
                    end else if (ascii == AsciiCr) begin
                        cur_col_d = '0;
                        cur_row_d = nl_row;
                    end else if (ascii == AsciiBs) begin
                        if (cur_col_q != '0) begin
                            we_d      = 1'b1;
                            wr_col_d  = cur_col_q - OneCol;
                            wr_row_d  = cur_row_q;
                            sym_d     = AsciiSpace;
                            cur_col_d = cur_col_q - OneCol;
                        end else if (cur_row_q != '0) begin
                            we_d      = 1'b1;
                            wr_col_d  = LastCol;
                            wr_row_d  = cur_row_q - OneRow;
                            sym_d     = AsciiSpace;
                            cur_col_d = LastCol;
                            cur_row_d = cur_row_q - OneRow;
                        end
                    end else if (ascii == AsciiFf) begin
                        state_d     = StClear;
                        busy_d      = 1'b1;
                        sweep_start = 1'b1;
                    end
                end else if (scancode_vld) begin
                    case (scancode)
                        ScanLeft:  if (cur_col_q != '0)     cur_col_d = cur_col_q - OneCol;
                        ScanRight: if (cur_col_q != LastCol) cur_col_d = cur_col_q + OneCol;
                        ScanUp:    if (cur_row_q != '0)     cur_row_d = cur_row_q - OneRow;
                        ScanDown:  if (cur_row_q != LastRow) cur_row_d = cur_row_q + OneRow;
                        default:   ;
                    endcase
                end
            end
            StClear: begin
                we_d       = 1'b1;
                wr_col_d   = sweep_col;
                wr_row_d   = sweep_row;
                sym_d      = AsciiSpace;
                sweep_step = 1'b1;
                if (sweep_done) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    cur_col_d = '0;
                    cur_row_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef CHAR_TERM_CLEAR_ON_RESET_EN
            state_q <= StClear;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
`endif
            cur_col_q <= '0;
            cur_row_q <= '0;
            we_q      <= 1'b0;
            wr_col_q  <= '0;
            wr_row_q  <= '0;
            sym_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rdy_q     <= (state_d == StIdle);
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            we_q      <= we_d;
            wr_col_q  <= wr_col_d;
            wr_row_q  <= wr_row_d;
            sym_q     <= sym_d;
        end
    end

    assign ascii_rdy     = rdy_q;
    assign busy          = busy_q;
    assign char_write_en = we_q;
    assign char_hpos     = wr_col_q;
    assign char_vpos     = wr_row_q;
    assign char_symbol   = sym_q;
    assign cursor_hpos   = cur_col_q;
    assign cursor_vpos   = cur_row_q;

endmodule
